// File: rtl/cook_timer_pkg.sv
// cook_timer_pkg
//   Shared definitions for the MM:SS cook timer:
//   - 2-bit state encoding presented on state_o (ST_IDLE/RUN/PAUSE/ALARM)
//   - BCD digit type and the all-zero MM:SS constant
//   - bcd2_inc_wrap(): two-digit BCD increment that wraps to 00 past a limit
package cook_timer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_ALARM = 2'b11;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [15:0] BCD_ZERO_MMSS = 16'h0000;

    // Increment a two-digit BCD value; a value at (or above) max_val wraps to 00.
    function automatic logic [7:0] bcd2_inc_wrap(input logic [7:0] bcd, input int max_val);
        int         bin;
        logic [7:0] r;
        bin = 10 * int'(bcd[7:4]) + int'(bcd[3:0]);
        if (bin >= max_val)
            r = 8'h00;
        else if (bcd[3:0] == 4'd9)
            r = {bcd[7:4] + 4'd1, 4'd0};
        else
            r = {bcd[7:4], bcd[3:0] + 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/bcd_mmss_down_counter.sv
// bcd_mmss_down_counter
//   Four-digit MM:SS BCD down counter. Seconds borrow from minutes and
//   restart at 59; the counter saturates at 00:00.
// Ports:
//   clk, reset_p      clock, asynchronous active-high reset
//   load_enable       load load_value (has priority over dec_tick)
//   load_value[15:0]  {min10, min1, sec10, sec1}
//   dec_tick          decrement by one second
//   value[15:0]       current {min10, min1, sec10, sec1}
//   is_zero           value == 00:00
module bcd_mmss_down_counter
    import cook_timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset_p,
    input  logic        load_enable,
    input  logic [15:0] load_value,
    input  logic        dec_tick,
    output logic [15:0] value,
    output logic        is_zero
);

    bcd_digit_t min10, min1, sec10, sec1;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            min10 <= 4'd0;
            min1  <= 4'd0;
            sec10 <= 4'd0;
            sec1  <= 4'd0;
        end else if (load_enable) begin
            {min10, min1, sec10, sec1} <= load_value;
        end else if (dec_tick) begin
            if (sec1 != 4'd0) begin
                sec1 <= sec1 - 4'd1;
            end else if (sec10 != 4'd0) begin
                sec10 <= sec10 - 4'd1;
                sec1  <= 4'd9;
            end else if (min1 != 4'd0) begin
                min1  <= min1 - 4'd1;
                sec10 <= 4'd5;
                sec1  <= 4'd9;
            end else if (min10 != 4'd0) begin
                min10 <= min10 - 4'd1;
                min1  <= 4'd9;
                sec10 <= 4'd5;
                sec1  <= 4'd9;
            end
        end
    end

    assign value   = {min10, min1, sec10, sec1};
    assign is_zero = (value == BCD_ZERO_MMSS);

endmodule

// File: rtl/cook_timer_fsm_param.sv
// cook_timer_fsm_param
//   MM:SS countdown cook timer: IDLE / RUN / PAUSE / ALARM state machine,
//   internal 1 s tick divider, set-time registers, pause without reload,
//   clear command and alarm auto-clear after ALARM_TIMEOUT_S ticks.
// Parameters:
//   TICK_DIV         clk cycles per 1 s tick
//   MIN_MAX          highest settable minute (1..99)
//   ALARM_TIMEOUT_S  ticks in ALARM before returning to IDLE (0 = never)
// Build option:
//   ALARM_BLINK_EN   defined: alarm_led blinks (TICK_DIV/2 high, then low)
//                    in ALARM; undefined: alarm_led steady high in ALARM
// Ports:
//   clk, reset_p       clock, asynchronous active-high reset
//   start_stop_pulse   start / pause / resume
//   inc_sec_pulse      set seconds +1 (IDLE only)
//   inc_min_pulse      set minutes +1 (IDLE only)
//   clear_pulse        abort to IDLE and zero the set time
//   alarm_off_pulse    acknowledge alarm
//   value[15:0]        {min10, min1, sec10, sec1} BCD
//   state_o[1:0]       00 IDLE, 01 RUN, 10 PAUSE, 11 ALARM
//   running_led        high in RUN
//   alarm_led          alarm indicator
//
// Command inputs are single-cycle pulses with no back-pressure: a pulse is
// consumed on the clk edge where it is high. When several are high together
// only the highest-priority one acts: clear > alarm_off > start_stop >
// inc_min > inc_sec.
module cook_timer_fsm_param
    import cook_timer_pkg::*;
#(
    parameter int TICK_DIV        = 100_000_000,
    parameter int MIN_MAX         = 59,
    parameter int ALARM_TIMEOUT_S = 30
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        start_stop_pulse,
    input  logic        inc_sec_pulse,
    input  logic        inc_min_pulse,
    input  logic        clear_pulse,
    input  logic        alarm_off_pulse,
    output logic [15:0] value,
    output logic [1:0]  state_o,
    output logic        running_led,
    output logic        alarm_led
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AL_W  = (ALARM_TIMEOUT_S > 1) ? $clog2(ALARM_TIMEOUT_S) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        PAUSE = ST_PAUSE,
        ALARM = ST_ALARM
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] tick_q, tick_d;
    logic [AL_W-1:0]  alarm_q, alarm_d;
    logic [7:0]       set_min_q, set_min_d, set_sec_q, set_sec_d;
    logic             cur_load, cur_dec, cur_zero;
    logic [15:0]      cur_value;
    logic             tick_term;
    logic             do_clear, do_aoff, do_ss, do_min, do_sec;

    // One-hot command after priority masking.
    assign do_clear = clear_pulse;
    assign do_aoff  = alarm_off_pulse  & ~do_clear;
    assign do_ss    = start_stop_pulse & ~do_clear & ~alarm_off_pulse;
    assign do_min   = inc_min_pulse    & ~do_clear & ~alarm_off_pulse & ~start_stop_pulse;
    assign do_sec   = inc_sec_pulse    & ~do_clear & ~alarm_off_pulse & ~start_stop_pulse
                                       & ~inc_min_pulse;

    assign tick_term = (tick_q == TICK_LAST);

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            alarm_q   <= '0;
            set_min_q <= 8'h00;
            set_sec_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            alarm_q   <= alarm_d;
            set_min_q <= set_min_d;
            set_sec_q <= set_sec_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        alarm_d   = alarm_q;
        set_min_d = set_min_q;
        set_sec_d = set_sec_q;
        cur_load  = 1'b0;
        cur_dec   = 1'b0;
        case (state_q)
            IDLE: begin
                tick_d  = '0;
                alarm_d = '0;
                if (do_clear) begin
                    set_min_d = 8'h00;
                    set_sec_d = 8'h00;
                end else if (do_ss) begin
                    if ({set_min_q, set_sec_q} != BCD_ZERO_MMSS) begin
                        cur_load = 1'b1;
                        state_d  = RUN;
                    end
                end else if (do_min) begin
                    set_min_d = bcd2_inc_wrap(set_min_q, MIN_MAX);
                end else if (do_sec) begin
                    set_sec_d = bcd2_inc_wrap(set_sec_q, 59);
                end
            end
            RUN: begin
                // The divider keeps running on the edge that pauses, so a
                // resume continues one count past where the pause arrived.
                tick_d = tick_term ? '0 : tick_q + 1'b1;
                if (do_clear) begin
                    state_d   = IDLE;
                    tick_d    = '0;
                    set_min_d = 8'h00;
                    set_sec_d = 8'h00;
                end else begin
                    cur_dec = tick_term;
                    // Reaching 00:00 wins over a simultaneous pause request.
                    if ((tick_term && cur_value == 16'h0001) || cur_zero) begin
                        state_d = ALARM;
                        tick_d  = '0;
                        alarm_d = '0;
                    end else if (do_ss) begin
                        state_d = PAUSE;
                    end
                end
            end
            PAUSE: begin
                if (do_clear) begin
                    state_d   = IDLE;
                    tick_d    = '0;
                    set_min_d = 8'h00;
                    set_sec_d = 8'h00;
                end else if (do_ss) begin
                    state_d = RUN;
                end
            end
            ALARM: begin
                tick_d = tick_term ? '0 : tick_q + 1'b1;
                if (tick_term)
                    alarm_d = alarm_q + 1'b1;
                if (do_clear) begin
                    state_d   = IDLE;
                    tick_d    = '0;
                    set_min_d = 8'h00;
                    set_sec_d = 8'h00;
                end else if (do_aoff || do_ss) begin
                    state_d = IDLE;
                    tick_d  = '0;
                end else if ((ALARM_TIMEOUT_S != 0) && tick_term &&
                             (int'(alarm_q) == ALARM_TIMEOUT_S - 1)) begin
                    state_d = IDLE;
                    tick_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    bcd_mmss_down_counter u_cur (
        .clk         (clk),
        .reset_p     (reset_p),
        .load_enable (cur_load),
        .load_value  ({set_min_q, set_sec_q}),
        .dec_tick    (cur_dec),
        .value       (cur_value),
        .is_zero     (cur_zero)
    );

    always_comb begin
        value = BCD_ZERO_MMSS;
        case (state_q)
            IDLE:        value = {set_min_q, set_sec_q};
            RUN, PAUSE:  value = cur_value;
            default:     value = BCD_ZERO_MMSS;
        endcase
    end

    assign state_o     = state_q;
    assign running_led = (state_q == RUN);

`ifdef ALARM_BLINK_EN
    // Tick divider restarts at 0 on ALARM entry, so the first half-period is high.
    localparam int HALF_I = (TICK_DIV / 2 > 0) ? TICK_DIV / 2 : 1;
    localparam logic [CNT_W-1:0] HALF = CNT_W'(HALF_I);
    assign alarm_led = (state_q == ALARM) && (tick_q < HALF);
`else
    assign alarm_led = (state_q == ALARM);
`endif

endmodule

// File: tb/tb_cook_timer_fsm_param.sv
// Bench for cook_timer_fsm_param (TICK_DIV=10, MIN_MAX=59, ALARM_TIMEOUT_S=2).
// The reference model tracks set time as integers, remaining time as total
// seconds and cycle counts since run start / alarm entry.
module tb_cook_timer_fsm_param;

    localparam int TD = 10;
    localparam int MM = 59;
    localparam int TO = 2;

    logic        clk = 1'b0;
    logic        reset_p = 1'b1;
    logic        start_stop_pulse = 1'b0;
    logic        inc_sec_pulse = 1'b0;
    logic        inc_min_pulse = 1'b0;
    logic        clear_pulse = 1'b0;
    logic        alarm_off_pulse = 1'b0;
    logic [15:0] value;
    logic [1:0]  state_o;
    logic        running_led;
    logic        alarm_led;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_q[$];

    cook_timer_fsm_param #(.TICK_DIV(TD), .MIN_MAX(MM), .ALARM_TIMEOUT_S(TO)) dut (
        .clk              (clk),
        .reset_p          (reset_p),
        .start_stop_pulse (start_stop_pulse),
        .inc_sec_pulse    (inc_sec_pulse),
        .inc_min_pulse    (inc_min_pulse),
        .clear_pulse      (clear_pulse),
        .alarm_off_pulse  (alarm_off_pulse),
        .value            (value),
        .state_o          (state_o),
        .running_led      (running_led),
        .alarm_led        (alarm_led)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    int m_state;   // 0 idle, 1 run, 2 pause, 3 alarm
    int m_set_m, m_set_s, m_rem, m_cyc, m_acyc;

    task automatic model_reset();
        m_state = 0; m_set_m = 0; m_set_s = 0; m_rem = 0; m_cyc = 0; m_acyc = 0;
    endtask

    task automatic model_step(input logic ss, input logic isec, input logic imin,
                              input logic clr, input logic aoff);
        int cmd; // 5 clear, 4 alarm_off, 3 start_stop, 2 inc_min, 1 inc_sec, 0 none
        cmd = clr ? 5 : aoff ? 4 : ss ? 3 : imin ? 2 : isec ? 1 : 0;
        case (m_state)
            0: begin
                if (cmd == 5) begin m_set_m = 0; m_set_s = 0; end
                else if (cmd == 3) begin
                    if (m_set_m * 60 + m_set_s > 0) begin
                        m_rem = m_set_m * 60 + m_set_s; m_cyc = 0; m_state = 1;
                    end
                end
                else if (cmd == 2) m_set_m = (m_set_m >= MM) ? 0 : m_set_m + 1;
                else if (cmd == 1) m_set_s = (m_set_s >= 59) ? 0 : m_set_s + 1;
            end
            1: begin
                m_cyc++;
                if (m_cyc == TD) begin m_cyc = 0; m_rem--; end
                if (cmd == 5) begin m_state = 0; m_set_m = 0; m_set_s = 0; end
                else if (m_rem == 0) begin m_state = 3; m_acyc = 0; end
                else if (cmd == 3) m_state = 2;
            end
            2: begin
                if (cmd == 5) begin m_state = 0; m_set_m = 0; m_set_s = 0; end
                else if (cmd == 3) m_state = 1;
            end
            default: begin
                m_acyc++;
                if (cmd == 5) begin m_state = 0; m_set_m = 0; m_set_s = 0; end
                else if (cmd == 4 || cmd == 3) m_state = 0;
                else if (TO != 0 && m_acyc == TO * TD) m_state = 0;
            end
        endcase
    endtask

    function automatic logic [15:0] bcd_mmss(input int m, input int s);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [15:0] exp_value();
        if (m_state == 0) return bcd_mmss(m_set_m, m_set_s);
        if (m_state == 1 || m_state == 2) return bcd_mmss(m_rem / 60, m_rem % 60);
        return 16'h0000;
    endfunction

    function automatic logic exp_alarm_led();
`ifdef ALARM_BLINK_EN
        return (m_state == 3) && ((m_acyc % TD) < TD / 2);
`else
        return (m_state == 3);
`endif
    endfunction

    // ---------------- driver ----------------
    // Drives one cycle of pulses at the falling edge, steps the model on the
    // rising edge and returns 1 time unit after it, with pulses released.
    task automatic cyc(input logic ss, input logic isec, input logic imin,
                       input logic clr, input logic aoff);
        @(negedge clk);
        start_stop_pulse = ss;
        inc_sec_pulse    = isec;
        inc_min_pulse    = imin;
        clear_pulse      = clr;
        alarm_off_pulse  = aoff;
        @(posedge clk);
        model_step(ss, isec, imin, clr, aoff);
        #1;
        start_stop_pulse = 1'b0;
        inc_sec_pulse    = 1'b0;
        inc_min_pulse    = 1'b0;
        clear_pulse      = 1'b0;
        alarm_off_pulse  = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_p = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_p = 1'b0;
        #1;
        n_checks++; if (value !== 16'h0000) begin n_errors++; $display("FAIL reset_value: got %h want 0000", value); end
        n_checks++; if (state_o !== 2'b00) begin n_errors++; $display("FAIL reset_state: got %b want 00", state_o); end
        n_checks++; if (running_led !== 1'b0) begin n_errors++; $display("FAIL reset_running_led: got %b want 0", running_led); end
        n_checks++; if (alarm_led !== 1'b0) begin n_errors++; $display("FAIL reset_alarm_led: got %b want 0", alarm_led); end
    endtask

    task automatic test_countdown();
        logic [15:0] e;
        repeat (3) cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        n_checks++; if (value !== 16'h0003) begin n_errors++; $display("FAIL cd_start_value: got %h want 0003", value); end
        n_checks++; if (running_led !== 1'b1) begin n_errors++; $display("FAIL cd_running_led: got %b want 1", running_led); end
        exp_q.push_back(16'h0002); exp_q.push_back(16'h0001); exp_q.push_back(16'h0000);
        for (int k = 1; k <= 30; k++) begin
            cyc(0, 0, 0, 0, 0);
            n_checks++; if (value !== exp_value()) begin n_errors++; $display("FAIL cd_model_value k=%0d: got %h want %h", k, value, exp_value()); end
            if (k % 10 == 0) begin
                e = exp_q.pop_front();
                n_checks++; if (value !== e) begin n_errors++; $display("FAIL cd_step k=%0d: got %h want %h", k, value, e); end
            end
        end
        n_checks++; if (state_o !== 2'b11) begin n_errors++; $display("FAIL cd_alarm_state: got %b want 11", state_o); end
        n_checks++; if (alarm_led !== 1'b1) begin n_errors++; $display("FAIL cd_alarm_led: got %b want 1", alarm_led); end
        n_checks++; if (running_led !== 1'b0) begin n_errors++; $display("FAIL cd_alarm_running_led: got %b want 0", running_led); end
        cyc(0, 0, 0, 0, 1);
        n_checks++; if (state_o !== 2'b00) begin n_errors++; $display("FAIL cd_alarm_off_state: got %b want 00", state_o); end
        n_checks++; if (value !== 16'h0003) begin n_errors++; $display("FAIL cd_set_preserved: got %h want 0003", value); end
        cyc(0, 0, 0, 1, 0);
    endtask

    task automatic test_minute_borrow();
        cyc(0, 0, 1, 0, 0);
        n_checks++; if (value !== 16'h0100) begin n_errors++; $display("FAIL mb_set: got %h want 0100", value); end
        cyc(1, 0, 0, 0, 0);
        repeat (10) cyc(0, 0, 0, 0, 0);
        n_checks++; if (value !== 16'h0059) begin n_errors++; $display("FAIL mb_value: got %h want 0059", value); end
        n_checks++; if (state_o !== 2'b01) begin n_errors++; $display("FAIL mb_state: got %b want 01", state_o); end
        cyc(0, 0, 0, 1, 0);
        n_checks++; if (value !== 16'h0000) begin n_errors++; $display("FAIL mb_clear_value: got %h want 0000", value); end
        n_checks++; if (state_o !== 2'b00) begin n_errors++; $display("FAIL mb_clear_state: got %b want 00", state_o); end
    endtask

    task automatic test_pause_resume();
        repeat (5) cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        repeat (14) cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        n_checks++; if (state_o !== 2'b10) begin n_errors++; $display("FAIL pr_pause_state: got %b want 10", state_o); end
        for (int k = 0; k < 100; k++) begin
            cyc(0, 0, 0, 0, 0);
            n_checks++; if (value !== 16'h0004 || state_o !== 2'b10) begin n_errors++; $display("FAIL pr_hold k=%0d: got %h/%b want 0004/10", k, value, state_o); end
        end
        cyc(1, 0, 0, 0, 0);
        for (int j = 1; j <= 5; j++) begin
            cyc(0, 0, 0, 0, 0);
            if (j < 5) begin
                n_checks++; if (value !== 16'h0004) begin n_errors++; $display("FAIL pr_resume j=%0d: got %h want 0004", j, value); end
            end else begin
                n_checks++; if (value !== 16'h0003) begin n_errors++; $display("FAIL pr_resume_dec: got %h want 0003", value); end
                n_checks++; if (state_o !== 2'b01) begin n_errors++; $display("FAIL pr_resume_state: got %b want 01", state_o); end
            end
        end
        cyc(0, 0, 0, 1, 0);
    endtask

    task automatic test_boundaries();
        repeat (2) cyc(0, 0, 1, 0, 0);
        for (int j = 1; j <= 60; j++) begin
            cyc(0, 1, 0, 0, 0);
            if (j == 59) begin
                n_checks++; if (value !== 16'h0259) begin n_errors++; $display("FAIL bd_sec59: got %h want 0259", value); end
            end
        end
        n_checks++; if (value !== 16'h0200) begin n_errors++; $display("FAIL bd_sec_wrap: got %h want 0200", value); end
        for (int j = 1; j <= 58; j++) begin
            cyc(0, 0, 1, 0, 0);
            if (j == 57) begin
                n_checks++; if (value !== 16'h5900) begin n_errors++; $display("FAIL bd_min59: got %h want 5900", value); end
            end
        end
        n_checks++; if (value !== 16'h0000) begin n_errors++; $display("FAIL bd_min_wrap: got %h want 0000", value); end
        cyc(1, 0, 0, 0, 0);
        n_checks++; if (state_o !== 2'b00) begin n_errors++; $display("FAIL bd_start_zero: got %b want 00", state_o); end
        n_checks++; if (running_led !== 1'b0) begin n_errors++; $display("FAIL bd_start_zero_led: got %b want 0", running_led); end
    endtask

    task automatic test_timeout();
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        repeat (10) cyc(0, 0, 0, 0, 0);
        n_checks++; if (state_o !== 2'b11) begin n_errors++; $display("FAIL to_alarm: got %b want 11", state_o); end
        for (int k = 1; k <= 20; k++) begin
            cyc(0, 0, 0, 0, 0);
            if (k < 20) begin
                n_checks++; if (state_o !== 2'b11) begin n_errors++; $display("FAIL to_hold k=%0d: got %b want 11", k, state_o); end
            end
        end
        n_checks++; if (state_o !== 2'b00) begin n_errors++; $display("FAIL to_auto_idle: got %b want 00", state_o); end
        n_checks++; if (alarm_led !== 1'b0) begin n_errors++; $display("FAIL to_led_off: got %b want 0", alarm_led); end
        cyc(1, 0, 0, 0, 0);
        repeat (10) cyc(0, 0, 0, 0, 0);
        n_checks++; if (state_o !== 2'b11) begin n_errors++; $display("FAIL to_alarm2: got %b want 11", state_o); end
        cyc(1, 0, 0, 0, 1);
        for (int k = 0; k < 12; k++) begin
            n_checks++; if (state_o !== 2'b00 || value !== 16'h0001) begin n_errors++; $display("FAIL to_ack_no_restart k=%0d: got %b/%h want 00/0001", k, state_o, value); end
            cyc(0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_async_reset();
        cyc(0, 0, 0, 1, 0);
        repeat (3) cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 0, 0);
        n_checks++; if (state_o !== 2'b01) begin n_errors++; $display("FAIL ar_pre_state: got %b want 01", state_o); end
        #2;
        reset_p = 1'b1;
        #1;
        n_checks++; if (value !== 16'h0000) begin n_errors++; $display("FAIL ar_value: got %h want 0000", value); end
        n_checks++; if (state_o !== 2'b00) begin n_errors++; $display("FAIL ar_state: got %b want 00", state_o); end
        n_checks++; if (running_led !== 1'b0 || alarm_led !== 1'b0) begin n_errors++; $display("FAIL ar_leds: got %b%b want 00", running_led, alarm_led); end
        reset_p = 1'b0;
        model_reset();
        cyc(1, 0, 0, 0, 0);
        n_checks++; if (state_o !== 2'b00 || value !== 16'h0000) begin n_errors++; $display("FAIL ar_start_ignored: got %b/%h want 00/0000", state_o, value); end
    endtask

    task automatic test_random();
        int r;
        logic ss, isec, imin, clr, aoff;
        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 99);
            ss = 0; isec = 0; imin = 0; clr = 0; aoff = 0;
            if (r < 5)       ss = 1;
            else if (r < 25) isec = 1;
            else if (r < 32) imin = 1;
            else if (r < 33) clr = 1;
            else if (r < 35) aoff = 1;
            else if (r == 35) begin ss = 1; aoff = 1; end
            else if (r == 36) begin ss = 1; clr = 1; end
            else if (r == 37) begin isec = 1; imin = 1; end
            cyc(ss, isec, imin, clr, aoff);
            n_checks++; if (value !== exp_value()) begin n_errors++; $display("FAIL rnd_value k=%0d: got %h want %h", k, value, exp_value()); end
            n_checks++; if (state_o !== 2'(m_state)) begin n_errors++; $display("FAIL rnd_state k=%0d: got %b want %0d", k, state_o, m_state); end
            n_checks++; if (running_led !== (m_state == 1)) begin n_errors++; $display("FAIL rnd_running_led k=%0d: got %b", k, running_led); end
            n_checks++; if (alarm_led !== exp_alarm_led()) begin n_errors++; $display("FAIL rnd_alarm_led k=%0d: got %b want %b", k, alarm_led, exp_alarm_led()); end
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_minute_borrow();
        test_pause_resume();
        test_boundaries();
        test_timeout();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cook_timer_fsm_param.md
Name: cook_timer_fsm_param

Overview:
Parametrised successor to the single-mode cook timer: an MM:SS countdown timer with an explicit state machine (IDLE, RUN, PAUSE, ALARM), pause/resume without reload, a clear command, and an alarm that clears itself after a timeout. It has its own tick divider and takes single-cycle command pulses from upstream button_cntr instances. Its 16-bit BCD value goes to the existing 7-segment scan path.

Parameters:
TICK_DIV, 100_000_000, clk cycles per 1 s tick (benches use 10).
MIN_MAX, 59, highest settable minute value, range 1..99.
ALARM_TIMEOUT_S, 30, ticks spent in ALARM before automatic return to IDLE; 0 disables auto-clear.

Ports:
clk  input  1  system clock
reset_p  input  1  asynchronous, active-high reset
start_stop_pulse  input  1  one-cycle pulse, start / pause / resume
inc_sec_pulse  input  1  one-cycle pulse, increment set seconds
inc_min_pulse  input  1  one-cycle pulse, increment set minutes
clear_pulse  input  1  one-cycle pulse, abort to IDLE and zero the set time
alarm_off_pulse  input  1  one-cycle pulse, acknowledge the alarm
value  output  16  {min10, min1, sec10, sec1} BCD
state_o  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 ALARM
running_led  output  1  high in RUN
alarm_led  output  1  alarm indicator

Behaviour:
- One clock, clk. reset_p is asynchronous and active-high. Reset gives: state IDLE, set time 00:00, current time 00:00, tick counter 0, value 16'h0000, running_led 0, alarm_led 0.
- All outputs are registered or decoded from registered state. A state change is visible the cycle after the pulse.
- Pulse priority within a cycle: clear > alarm_off > start_stop > inc_min > inc_sec. At most one pulse acts per cycle.
- IDLE:
  - value shows the set time.
  - inc_sec: set seconds +1, 59 wraps to 00, no carry into minutes.
  - inc_min: set minutes +1, MIN_MAX wraps to 00.
  - start_stop with set time ≠ 00:00: load current := set, tick counter := 0, go to RUN.
  - start_stop with set time = 00:00 is ignored.
  - clear: set time := 00:00.
- RUN:
  - value shows the current time.
  - Tick counter counts 0..TICK_DIV-1. On the terminal count it returns to 0 and the current time decrements in BCD: sec1 borrows to sec10, 00 seconds borrows from minutes and becomes 59.
  - The first decrement happens exactly TICK_DIV cycles after the start pulse.
  - If the decrement reaches 00:00, go to ALARM on the same edge.
  - start_stop: go to PAUSE; tick counter holds its value.
  - clear: go to IDLE, set time := 00:00.
  - inc pulses are ignored.
- PAUSE:
  - value shows the frozen current time.
  - start_stop: go to RUN without reload; tick counter continues from its held value.
  - clear: go to IDLE, set time := 00:00.
  - inc pulses are ignored.
- ALARM:
  - value = 16'h0000. alarm_led asserted. Set time is preserved for a quick restart.
  - alarm_off, start_stop or clear: go to IDLE (clear also zeroes the set time).
  - If ALARM_TIMEOUT_S ≠ 0: count ALARM_TIMEOUT_S ticks, then return to IDLE automatically.
- Width rules: tick counter width is $clog2(TICK_DIV). Every BCD digit stays within 0..9. The minute tens digit never exceeds MIN_MAX/10.
- Reset asserted in any state returns everything to reset values immediately. No pending tick survives reset.

Optional Feature:
ALARM_BLINK_EN
- Defined: in ALARM, alarm_led toggles every TICK_DIV/2 cycles, starting high on entry.
- Not defined: alarm_led is steady high throughout ALARM.
- running_led and value are identical in both builds.

Decomposition:
- Shared package cook_timer_pkg holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_PAUSE, ST_ALARM (2-bit);
  - a BCD digit typedef (4-bit);
  - constant BCD_ZERO_MMSS = 16'h0000.
- One sub-module: bcd_mmss_down_counter.
  - Inputs: load_enable, load value, dec_tick.
  - Outputs: the MM:SS BCD value and an is_zero flag.
  - Instantiated once for the current time.
- The FSM, tick divider and set-time registers live in the top module.

Test Plan:
- TICK_DIV=10. Set 00:03 (three inc_sec), start → value 0003 → 0002 → 0001 → 0000 at cycles 10/20/30 after start; state_o=11 and alarm_led=1 on the 30th-cycle edge.
- Set 01:00, start, wait 10 cycles → value 0059 (minute borrow), state_o=01.
- Set 00:05, start, pause at cycle 15 → value 0004 held for 100 cycles. Resume → 0003 appears 5 cycles after resume (counter continued from 5).
- Boundaries:
  - 60 inc_sec pulses in IDLE → set seconds return to 00 with minutes unchanged.
  - MIN_MAX=59: 60 inc_min pulses → minutes return to 00.
  - start with 00:00 → state stays 00.
- ALARM_TIMEOUT_S=2, reach ALARM → IDLE after 20 cycles. A second run where alarm_off_pulse and start_stop_pulse arrive in the same cycle → IDLE, and no new run starts.
- reset_p pulsed asynchronously mid-RUN (between clk edges) → value 0000, state 00 and both LEDs 0 before the next clk edge. A start_stop_pulse immediately after reset is ignored (set 00:00).
